nibble_alu: RTL and testbench



---
 rtl/nibble_alu.sv | 107 ++++++++++
 tb/tb_nibble_alu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_alu.sv
// Accumulator ALU for the Nibbler datapath with 74181-style function encoding.
// Operand A is the accumulator, operand B is dataIn; every clock edge writes the result back.
module nibble_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [3:0]       func,
  input  logic             mode,
  input  logic             carryIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             carryOut,
  output logic             zeroOut
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] logic_f;
  logic [WIDTH-1:0] arith_x, arith_y;
  logic [WIDTH:0]   arith_sum;

  assign op_a = acc_q;
  assign op_b = dataIn;

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    logic_f = ALL_ZERO;
    unique case (func)
      4'b0000: logic_f = ~op_a;
      4'b0001: logic_f = ~(op_a | op_b);
      4'b0010: logic_f = ~op_a & op_b;
      4'b0011: logic_f = ALL_ZERO;
      4'b0100: logic_f = ~(op_a & op_b);
      4'b0101: logic_f = ~op_b;
      4'b0110: logic_f = op_a ^ op_b;
      4'b0111: logic_f = op_a & ~op_b;
      4'b1000: logic_f = ~op_a | op_b;
      4'b1001: logic_f = ~(op_a ^ op_b);
      4'b1010: logic_f = op_b;
      4'b1011: logic_f = op_a & op_b;
      4'b1100: logic_f = ALL_ONES;
      4'b1101: logic_f = op_a | ~op_b;
      4'b1110: logic_f = op_a | op_b;
      4'b1111: logic_f = op_a;
      default: logic_f = ALL_ZERO;
    endcase
  end

  // Arithmetic functions all reduce to X + Y + carryIn; only the operand pair differs.
  always_comb begin
    arith_x = op_a;
    arith_y = ALL_ZERO;
    unique case (func)
      4'b0000: begin arith_x = op_a;            arith_y = ALL_ZERO;      end
      4'b0001: begin arith_x = op_a | op_b;     arith_y = ALL_ZERO;      end
      4'b0010: begin arith_x = op_a | ~op_b;    arith_y = ALL_ZERO;      end
      4'b0011: begin arith_x = ALL_ZERO;        arith_y = ALL_ONES;      end
      4'b0100: begin arith_x = op_a;            arith_y = op_a & ~op_b;  end
      4'b0101: begin arith_x = op_a | op_b;     arith_y = op_a & ~op_b;  end
      4'b0110: begin arith_x = op_a;            arith_y = ~op_b;         end
      4'b0111: begin arith_x = op_a & ~op_b;    arith_y = ALL_ONES;      end
      4'b1000: begin arith_x = op_a;            arith_y = op_a & op_b;   end
      4'b1001: begin arith_x = op_a;            arith_y = op_b;          end
      4'b1010: begin arith_x = op_a | ~op_b;    arith_y = op_a & op_b;   end
      4'b1011: begin arith_x = op_a & op_b;     arith_y = ALL_ONES;      end
      4'b1100: begin arith_x = op_a;            arith_y = op_a;          end
      4'b1101: begin arith_x = op_a | op_b;     arith_y = op_a;          end
      4'b1110: begin arith_x = op_a | ~op_b;    arith_y = op_a;          end
      4'b1111: begin arith_x = op_a;            arith_y = ALL_ONES;      end
      default: begin arith_x = op_a;            arith_y = ALL_ZERO;      end
    endcase
  end

  assign arith_sum = {1'b0, arith_x} + {1'b0, arith_y} + {{WIDTH{1'b0}}, carryIn};

  // Logic mode ignores carryIn and always clears the carry flag.
  always_comb begin
    acc_d   = logic_f;
    carry_d = 1'b0;
    if (!mode) begin
      acc_d   = arith_sum[WIDTH-1:0];
      carry_d = arith_sum[WIDTH];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= ALL_ZERO;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign dataOut  = acc_q;
  assign carryOut = carry_q;
  assign zeroOut  = (acc_q == ALL_ZERO);

endmodule

// File: tb/tb_nibble_alu.sv
// Scoreboard bench for nibble_alu: stimulus pushes expected results from a reference model,
// a monitor pops and compares after every rising edge.
module tb_nibble_alu;

  logic       clk;
  logic       reset;
  logic [3:0] dataIn;
  logic [3:0] func;
  logic       mode;
  logic       carryIn;
  logic [3:0] dataOut;
  logic       carryOut;
  logic       zeroOut;

  nibble_alu #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .dataIn   (dataIn),
    .func     (func),
    .mode     (mode),
    .carryIn  (carryIn),
    .dataOut  (dataOut),
    .carryOut (carryOut),
    .zeroOut  (zeroOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int f;
    int c;
    int z;
  } exp_t;

  exp_t sb_q[$];
  int   model_acc;
  int   n_checks;
  int   n_fails;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: result computed with plain integer arithmetic on the 74181 tables.
  function automatic exp_t ref_alu(int a, int b, int fn, int md, int ci);
    exp_t r;
    int   na, nb, x, y, s;
    na = (~a) & 15;
    nb = (~b) & 15;
    r.c = 0;
    if (md == 1) begin
      case (fn)
        0:  r.f = na;
        1:  r.f = (~(a | b)) & 15;
        2:  r.f = na & b;
        3:  r.f = 0;
        4:  r.f = (~(a & b)) & 15;
        5:  r.f = nb;
        6:  r.f = a ^ b;
        7:  r.f = a & nb;
        8:  r.f = na | b;
        9:  r.f = (~(a ^ b)) & 15;
        10: r.f = b;
        11: r.f = a & b;
        12: r.f = 15;
        13: r.f = a | nb;
        14: r.f = a | b;
        default: r.f = a;
      endcase
    end else begin
      case (fn)
        0:  begin x = a;      y = 0;      end
        1:  begin x = a | b;  y = 0;      end
        2:  begin x = a | nb; y = 0;      end
        3:  begin x = 0;      y = 15;     end
        4:  begin x = a;      y = a & nb; end
        5:  begin x = a | b;  y = a & nb; end
        6:  begin x = a;      y = nb;     end
        7:  begin x = a & nb; y = 15;     end
        8:  begin x = a;      y = a & b;  end
        9:  begin x = a;      y = b;      end
        10: begin x = a | nb; y = a & b;  end
        11: begin x = a & b;  y = 15;     end
        12: begin x = a;      y = a;      end
        13: begin x = a | b;  y = a;      end
        14: begin x = a | nb; y = a;      end
        default: begin x = a; y = 15;     end
      endcase
      s   = x + y + ci;
      r.f = s % 16;
      r.c = s / 16;
    end
    r.z = (r.f == 0) ? 1 : 0;
    return r;
  endfunction

  // Called at a falling edge: drive inputs for the next rising edge and record the expected result.
  task automatic step(input int din, input int fn, input int md, input int ci);
    exp_t e;
    dataIn  = din[3:0];
    func    = fn[3:0];
    mode    = md[0];
    carryIn = ci[0];
    e = ref_alu(model_acc, din, fn, md, ci);
    sb_q.push_back(e);
    model_acc = e.f;
    @(negedge clk);
  endtask

  task automatic load(input int v);
    step(v, 10, 1, 0);
  endtask

  // Called at a falling edge: assert reset between edges, check it acts at once and holds.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("reset_async_data", dataOut, 0);
    check("reset_async_carry", carryOut, 0);
    check("reset_async_zero", zeroOut, 1);
    @(posedge clk);
    #1;
    check("reset_hold_data", dataOut, 0);
    check("reset_hold_zero", zeroOut, 1);
    @(negedge clk);
    reset     = 1'b0;
    model_acc = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("dataOut", dataOut, e.f);
        check("carryOut", carryOut, e.c);
        check("zeroOut", zeroOut, e.z);
      end
    end
  end

  initial begin : stimulus
    n_checks  = 0;
    n_fails   = 0;
    model_acc = 0;
    reset     = 1'b1;
    dataIn    = 4'b0110;
    func      = 4'b1010;
    mode      = 1'b1;
    carryIn   = 1'b0;
    #1;
    check("init_reset_data", dataOut, 0);
    check("init_reset_carry", carryOut, 0);
    check("init_reset_zero", zeroOut, 1);
    @(negedge clk);
    reset = 1'b0;

    // Async reset from a non-zero accumulator
    step(6, 10, 1, 0);
    do_reset();

    // Pass-through
    step(1, 10, 1, 0);
    step(3, 10, 1, 0);
    step(12, 10, 1, 0);

    // Add with carry
    load(5);
    step(3, 9, 0, 0);
    step(9, 9, 0, 0);

    // Subtract
    load(6);
    step(2, 6, 0, 1);
    load(2);
    step(6, 6, 0, 1);
    step(6, 6, 0, 0);

    // Logic ops with carryIn high
    load(12);
    step(10, 6, 1, 1);
    load(12);
    step(10, 11, 1, 1);
    load(12);
    step(10, 0, 1, 1);

    // Decrement through zero, and constant-ones function
    load(1);
    step(0, 15, 0, 0);
    step(0, 15, 0, 0);
    step(0, 3, 0, 0);
    step(0, 3, 0, 1);

    // Random traffic with occasional mid-operation resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else step($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 1));
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
